// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states, ALU and mux select codes.
package cpu_defs_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned STATE_W  = 3;

  // Instruction opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

  // Control FSM states
  typedef enum logic [STATE_W-1:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_LS  = 3'b010,
    S_MEM     = 3'b011,
    S_WB_LD   = 3'b100,
    S_EXE_BR  = 3'b101,
    S_EXE_AL  = 3'b110,
    S_WB_AL   = 3'b111
  } state_t;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

  // PC source select
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  // Destination register select
  localparam logic [1:0] REGOUT_RT = 2'b00;
  localparam logic [1:0] REGOUT_RD = 2'b01;
  localparam logic [1:0] REGOUT_RA = 2'b10;

  // Full set of datapath control signals for one cycle
  typedef struct packed {
    logic               pc_wre;
    logic               ir_wre;
    logic               ins_mem_rw;
    logic               reg_wre;
    logic [1:0]         reg_out;
    logic               wr_reg_data;
    logic               alu_src_a;
    logic               alu_src_b;
    logic               alu_m2reg;
    logic               ext_sel;
    logic               data_mem_rw;
    logic [1:0]         pc_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // True for register/immediate arithmetic-logic instructions
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // True for any opcode the CPU implements
  function automatic logic is_defined_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
      default: return is_alu_op(op);
    endcase
  endfunction

  // ALU function required by an ALU-class opcode
  function automatic logic [ALUOP_W-1:0] alu_op_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_SLL:         return ALU_SLL;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLT:         return ALU_SLT;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational control decoder: maps (state, opcode, zero) to every datapath control.
module multicycle_control_decode
  import cpu_defs_pkg::*;
(
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output ctrl_t               ctrl
);

  logic imm_form;

  assign imm_form = (opcode == OP_ADDI) || (opcode == OP_ORI);

  // Per-state control decode; anything not driven below stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.ir_wre     = 1'b1;
        ctrl.ins_mem_rw = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PCSRC_JMP;
          end
          OP_JR: begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PCSRC_RS;
          end
          OP_JAL: begin
            ctrl.pc_wre      = 1'b1;
            ctrl.pc_src      = PCSRC_JMP;
            ctrl.reg_wre     = 1'b1;
            ctrl.reg_out     = REGOUT_RA;
            ctrl.wr_reg_data = 1'b0;
          end
          default: begin
            // Unknown opcodes retire here as a nop
            if (!is_defined_op(opcode)) begin
              ctrl.pc_wre = 1'b1;
              ctrl.pc_src = PCSRC_SEQ;
            end
          end
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        ctrl.alu_op    = alu_op_of(opcode);
        ctrl.alu_src_b = imm_form;
        ctrl.alu_src_a = (opcode == OP_SLL);
        ctrl.ext_sel   = (opcode == OP_ADDI);
        ctrl.reg_out   = imm_form ? REGOUT_RT : REGOUT_RD;
        if (state == S_WB_AL) begin
          ctrl.reg_wre     = 1'b1;
          ctrl.wr_reg_data = 1'b1;
          ctrl.pc_wre      = 1'b1;
          ctrl.pc_src      = PCSRC_SEQ;
        end
      end
      S_EXE_BR: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.ext_sel = 1'b1;
        ctrl.pc_wre  = 1'b1;
        ctrl.pc_src  = zero ? PCSRC_BR : PCSRC_SEQ;
      end
      S_EXE_LS, S_MEM: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
        if ((state == S_MEM) && (opcode == OP_SW)) begin
          ctrl.data_mem_rw = 1'b1;
          ctrl.pc_wre      = 1'b1;
          ctrl.pc_src      = PCSRC_SEQ;
        end
      end
      S_WB_LD: begin
        ctrl.reg_wre     = 1'b1;
        ctrl.alu_m2reg   = 1'b1;
        ctrl.wr_reg_data = 1'b1;
        ctrl.reg_out     = REGOUT_RT;
        ctrl.pc_wre      = 1'b1;
        ctrl.pc_src      = PCSRC_SEQ;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle CPU: sequences IF/ID/EXE/MEM/WB and drives the datapath controls.
module multicycle_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned OPW    = 6,
  parameter int unsigned ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    Opcode,
  input  logic              Zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              RegWre,
  output logic [1:0]        RegOut,
  output logic              WrRegData,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              ALUM2Reg,
  output logic              ExtSel,
  output logic              DataMemRW,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [2:0]        State
);

  state_t              state;
  state_t              state_next;
  logic [OPCODE_W-1:0] op;
  ctrl_t               ctrl;

  assign op = OPCODE_W'(Opcode);

  // State register; reset returns to instruction fetch immediately
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_IF;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = S_IF;
    case (state)
      S_IF: state_next = S_ID;
      S_ID: begin
        case (op)
          OP_J, OP_JR, OP_JAL: state_next = S_IF;
          OP_BEQ:              state_next = S_EXE_BR;
          OP_LW, OP_SW:        state_next = S_EXE_LS;
          OP_HALT:             state_next = S_ID;
          default:             state_next = is_alu_op(op) ? S_EXE_AL : S_IF;
        endcase
      end
      S_EXE_AL: state_next = S_WB_AL;
      S_WB_AL:  state_next = S_IF;
      S_EXE_BR: state_next = S_IF;
      S_EXE_LS: state_next = S_MEM;
      S_MEM:    state_next = (op == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_next = S_IF;
    endcase
  end

  // Output decode from current state and instruction fields
  multicycle_control_decode u_decode (
    .state  (state),
    .opcode (op),
    .zero   (Zero),
    .ctrl   (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign RegWre    = ctrl.reg_wre;
  assign RegOut    = ctrl.reg_out;
  assign WrRegData = ctrl.wr_reg_data;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUM2Reg  = ctrl.alu_m2reg;
  assign ExtSel    = ctrl.ext_sel;
  assign DataMemRW = ctrl.data_mem_rw;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ALUOPW'(ctrl.alu_op);
  assign State     = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit against a per-instruction step-table model.
module tb_multicycle_control_unit;

  // Instruction classes used by the reference model
  localparam int C_NOP  = 0;
  localparam int C_J    = 1;
  localparam int C_JR   = 2;
  localparam int C_JAL  = 3;
  localparam int C_BEQ  = 4;
  localparam int C_LW   = 5;
  localparam int C_SW   = 6;
  localparam int C_HALT = 7;
  localparam int C_ALU  = 8;

  logic        CLK;
  logic        Reset;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        PCWre, IRWre, InsMemRW, RegWre, WrRegData;
  logic        ALUSrcA, ALUSrcB, ALUM2Reg, ExtSel, DataMemRW;
  logic [1:0]  RegOut, PCSrc;
  logic [2:0]  ALUOp;
  logic [2:0]  State;
  logic [17:0] obs;

  int checks   = 0;
  int failures = 0;

  multicycle_control_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .RegOut    (RegOut),
    .WrRegData (WrRegData),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUM2Reg  (ALUM2Reg),
    .ExtSel    (ExtSel),
    .DataMemRW (DataMemRW),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .State     (State)
  );

  assign obs = {PCWre, IRWre, InsMemRW, RegWre, RegOut, WrRegData, ALUSrcA,
                ALUSrcB, ALUM2Reg, ExtSel, DataMemRW, PCSrc, ALUOp};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b011000, 6'b100110: return C_ALU;
      6'b110000: return C_SW;
      6'b110001: return C_LW;
      6'b110100: return C_BEQ;
      6'b111000: return C_J;
      6'b111001: return C_JR;
      6'b111010: return C_JAL;
      6'b111111: return C_HALT;
      default:   return C_NOP;
    endcase
  endfunction

  // Cycles from one fetch to the next
  function automatic int path_len(input logic [5:0] op);
    case (op_class(op))
      C_BEQ:       return 3;
      C_ALU, C_SW: return 4;
      C_LW:        return 5;
      default:     return 2;
    endcase
  endfunction

  // State code visited at step k of an instruction
  function automatic logic [2:0] exp_state(input logic [5:0] op, input int k);
    int c;
    c = op_class(op);
    if (k == 0) return 3'd0;
    if (k == 1) return 3'd1;
    if (k == 2) begin
      if (c == C_BEQ) return 3'd5;
      if (c == C_ALU) return 3'd6;
      return 3'd2;
    end
    if (k == 3) return (c == C_ALU) ? 3'd7 : 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] op);
    case (op)
      6'b000001:            return 3'd1;
      6'b011000:            return 3'd2;
      6'b010000, 6'b010010: return 3'd3;
      6'b010001:            return 3'd4;
      6'b100110:            return 3'd5;
      default:              return 3'd0;
    endcase
  endfunction

  // Expected control vector at step k of an instruction
  function automatic logic [17:0] exp_ctrl(input logic [5:0] op, input int k, input logic z);
    logic pcw, irw, imr, rw, wrd, sa, sb, m2r, ext, dmw;
    logic [1:0] ro, pcs;
    logic [2:0] alu;
    logic imm;
    int c;
    c = op_class(op);
    imm = (op == 6'b000010) || (op == 6'b010010);
    pcw = 0; irw = 0; imr = 0; rw = 0; wrd = 0; sa = 0; sb = 0;
    m2r = 0; ext = 0; dmw = 0; ro = 2'd0; pcs = 2'd0; alu = 3'd0;
    if (k == 0) begin
      irw = 1; imr = 1;
    end else if (k == 1) begin
      if (c == C_J)   begin pcw = 1; pcs = 2'd3; end
      if (c == C_JR)  begin pcw = 1; pcs = 2'd2; end
      if (c == C_JAL) begin pcw = 1; pcs = 2'd3; rw = 1; ro = 2'd2; wrd = 0; end
      if (c == C_NOP) begin pcw = 1; pcs = 2'd0; end
    end else if (c == C_ALU) begin
      alu = alu_code(op);
      sb  = imm;
      sa  = (op == 6'b011000);
      ext = (op == 6'b000010);
      ro  = imm ? 2'd0 : 2'd1;
      if (k == 3) begin rw = 1; wrd = 1; pcw = 1; end
    end else if (c == C_BEQ) begin
      alu = 3'd1; ext = 1; pcw = 1; pcs = z ? 2'd1 : 2'd0;
    end else if (k == 4) begin
      rw = 1; m2r = 1; wrd = 1; pcw = 1;
    end else begin
      sb = 1; ext = 1;
      if (k == 3 && c == C_SW) begin dmw = 1; pcw = 1; end
    end
    return {pcw, irw, imr, rw, ro, wrd, sa, sb, m2r, ext, dmw, pcs, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Runs one instruction from fetch; optionally pulls reset at step abort_at
  task automatic run_instr(input logic [5:0] op, input logic zbr, input int abort_at);
    int   n;
    int   pulses;
    logic z;
    n = path_len(op);
    pulses = 0;
    Opcode = op;
    for (int k = 0; k < n; k++) begin
      z = (k == 2 && op_class(op) == C_BEQ) ? zbr : 1'($urandom);
      Zero = z;
      #1;
      check($sformatf("state op=%b step=%0d", op, k), 32'(State), 32'(exp_state(op, k)));
      check($sformatf("ctrl op=%b step=%0d", op, k), 32'(obs), 32'(exp_ctrl(op, k, z)));
      pulses += int'(PCWre);
      if (k == abort_at) begin
        Reset = 1'b0;
        #1;
        check("abort_state", 32'(State), 32'd0);
        check("abort_regwre", 32'(RegWre), 32'd0);
        check("abort_ctrl", 32'(obs), 32'(exp_ctrl(op, 0, z)));
        @(negedge CLK);
        Reset = 1'b1;
        return;
      end
      @(negedge CLK);
    end
    check($sformatf("pcwre_pulses op=%b", op), 32'(pulses), 32'd1);
  endtask

  logic [5:0] alu_ops [8];
  logic [5:0] all_ops [14];
  logic [5:0] rop;

  initial begin
    alu_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                6'b010001, 6'b010010, 6'b011000, 6'b100110};
    all_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                6'b110100, 6'b111000, 6'b111001, 6'b111010};

    // Reset held for two cycles
    Reset  = 1'b0;
    Opcode = 6'b111000;
    Zero   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("reset_state", 32'(State), 32'd0);
    check("reset_irwre", 32'(IRWre), 32'd1);
    check("reset_pcwre", 32'(PCWre), 32'd0);
    check("reset_ctrl", 32'(obs), 32'(exp_ctrl(6'b111000, 0, 1'b0)));
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    check("release_state", 32'(State), 32'd1);
    check("release_ctrl_j", 32'(obs), 32'(exp_ctrl(6'b111000, 1, 1'b0)));
    @(negedge CLK);
    @(negedge CLK);

    // Directed instructions
    run_instr(6'b000000, 1'b0, -1);
    run_instr(6'b110001, 1'b0, -1);
    run_instr(6'b110000, 1'b0, -1);
    run_instr(6'b110100, 1'b1, -1);
    run_instr(6'b110100, 1'b0, -1);
    run_instr(6'b111010, 1'b0, -1);
    run_instr(6'b111000, 1'b0, -1);
    run_instr(6'b111001, 1'b0, -1);
    run_instr(6'b001111, 1'b0, -1);
    for (int i = 0; i < 8; i++) run_instr(alu_ops[i], 1'b0, -1);

    // Halt parks in decode until reset
    Opcode = 6'b111111;
    Zero   = 1'($urandom);
    #1;
    check("halt_fetch_state", 32'(State), 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      Zero = 1'($urandom);
      #1;
      check($sformatf("halt_state cyc=%0d", i), 32'(State), 32'd1);
      check($sformatf("halt_ctrl cyc=%0d", i), 32'(obs), 32'd0);
      @(negedge CLK);
    end
    Reset = 1'b0;
    #1;
    check("halt_reset_state", 32'(State), 32'd0);
    check("halt_reset_ctrl", 32'(obs), 32'(exp_ctrl(6'b111111, 0, 1'b0)));
    @(negedge CLK);
    Reset = 1'b1;

    // Reset during ALU write-back must not retire the write
    run_instr(6'b000000, 1'b0, 3);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) begin
        rop = 6'($urandom);
        if (rop == 6'b111111) rop = 6'b101010;
      end else begin
        rop = all_ops[$urandom_range(13)];
      end
      run_instr(rop, 1'($urandom), -1);
    end

    #1;
    check("final_state", 32'(State), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
